// File: rtl/anton_neopixel_uart_loader.sv
// UART-to-bus loader: parses A5/addr/len/data frames from an 8N1 serial line
// and turns each data byte into a three-cycle strobed write on the neopixel byte bus.
module anton_neopixel_uart_loader #(
    parameter int unsigned CLK_DIV   = 61,
    parameter int unsigned TIMEOUT   = 70000,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk7mhz,
    input  logic        reset,
    input  logic        uartRx,
    output logic [13:0] busAddr,
    output logic [7:0]  busDataIn,
    output logic        busWrite,
    output logic        busRead,
    output logic        busClk,
    output logic        busy,
    output logic        frameDone,
    output logic        frameError
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned CNT_W = 9;
    localparam logic [DIV_W-1:0] BIT_END  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] HALF_END = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [TO_W-1:0]  TO_END   = TO_W'(TIMEOUT);

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK
    } rx_state_t;

    typedef enum logic [2:0] {
        P_SYNC, P_ADDR_HI, P_ADDR_LO, P_LEN, P_DATA, P_W0, P_W1, P_W2
    } p_state_t;

    logic             rx_s1;
    logic             rx_s2;
    logic             rx_prev;
    rx_state_t        rx_state;
    logic [DIV_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic [7:0]       rx_byte;
    logic             rx_valid;
    logic             rx_ferr;

    p_state_t         p_state;
    logic [13:0]      addr;
    logic [CNT_W-1:0] count;
    logic [TO_W-1:0]  to_cnt;
    logic             timed_c;
    logic             timeout_c;

    assign busRead = 1'b0;

    // Two-flop synchroniser plus one delay stage for falling-edge detection
    always_ff @(posedge clk7mhz) begin
        if (reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uartRx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Receiver: start bit confirmed at half a bit, data/stop sampled a full bit apart
    always_ff @(posedge clk7mhz) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_END) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + DIV_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_END) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + DIV_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_END) begin
                        rx_cnt <= '0;
                        if (rx_s2) begin
                            rx_valid <= 1'b1;
                            rx_byte  <= rx_shift;
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_ferr  <= 1'b1;
                            rx_state <= RX_BREAK;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + DIV_W'(1);
                    end
                end
                RX_BREAK: begin
                    // A low stop bit may be a break; wait for the line to recover
                    if (rx_s2) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign timed_c   = (p_state == P_ADDR_HI) || (p_state == P_ADDR_LO) ||
                       (p_state == P_LEN)     || (p_state == P_DATA);
    assign timeout_c = timed_c && (to_cnt == TO_END);

    // Frame parser and bus write sequencer
    always_ff @(posedge clk7mhz) begin
        if (reset) begin
            p_state    <= P_SYNC;
            addr       <= '0;
            count      <= '0;
            to_cnt     <= '0;
            busAddr    <= '0;
            busDataIn  <= '0;
            busWrite   <= 1'b0;
            busClk     <= 1'b0;
            busy       <= 1'b0;
            frameDone  <= 1'b0;
            frameError <= 1'b0;
        end else begin
            frameDone  <= 1'b0;
            frameError <= 1'b0;
            if (!timed_c || rx_valid || timeout_c) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            if (rx_ferr || timeout_c) begin
                frameError <= 1'b1;
                busWrite   <= 1'b0;
                busClk     <= 1'b0;
                busy       <= 1'b0;
                p_state    <= P_SYNC;
            end else begin
                case (p_state)
                    P_SYNC: begin
                        if (rx_valid && (rx_byte == SYNC_BYTE)) begin
                            busy    <= 1'b1;
                            p_state <= P_ADDR_HI;
                        end
                    end
                    P_ADDR_HI: begin
                        if (rx_valid) begin
                            addr[13:8] <= rx_byte[5:0];
                            p_state    <= P_ADDR_LO;
                        end
                    end
                    P_ADDR_LO: begin
                        if (rx_valid) begin
                            addr[7:0] <= rx_byte;
                            p_state   <= P_LEN;
                        end
                    end
                    P_LEN: begin
                        if (rx_valid) begin
                            count   <= CNT_W'(rx_byte) + CNT_W'(1);
                            p_state <= P_DATA;
                        end
                    end
                    P_DATA: begin
                        if (rx_valid) begin
                            busAddr   <= addr;
                            busDataIn <= rx_byte;
                            busWrite  <= 1'b1;
                            addr      <= addr + 14'd1;
                            count     <= count - CNT_W'(1);
                            p_state   <= P_W0;
                        end
                    end
                    P_W0: begin
                        busClk  <= 1'b1;
                        p_state <= P_W1;
                    end
                    P_W1: begin
                        busClk   <= 1'b0;
                        busWrite <= 1'b0;
                        p_state  <= P_W2;
                    end
                    P_W2: begin
                        if (count == '0) begin
                            frameDone <= 1'b1;
                            busy      <= 1'b0;
                            p_state   <= P_SYNC;
                        end else begin
                            p_state <= P_DATA;
                        end
                    end
                    default: p_state <= P_SYNC;
                endcase
            end
        end
    end

endmodule
